filtered_synchronizer: RTL

FILTERED_SYNCHRONIZER -- requirements
Module: filtered_synchronizer

---
 rtl/filtered_synchronizer_pkg.sv | 14 +
 rtl/glitch_filter.sv | 61 ++++++
 rtl/filtered_synchronizer.sv | 53 +++++
 3 files changed

// File: rtl/filtered_synchronizer_pkg.sv
// Shared limits and helpers for the filtered synchronizer and its per-channel glitch filter.
package filtered_synchronizer_pkg;

  localparam int unsigned MAX_WIDTH         = 64;
  localparam int unsigned MIN_STAGES        = 2;
  localparam int unsigned MAX_STAGES        = 8;
  localparam int unsigned MAX_FILTER_CYCLES = 1024;

  // A counter that only ever reaches cycles-1 needs $clog2(cycles) bits, never fewer than one.
  function automatic int unsigned filter_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// One channel of the filter: a stability counter, the registered output level and
// registered one-cycle edge pulses.
module glitch_filter
  import filtered_synchronizer_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sync,
  output logic data_out,
  output logic rising_edge,
  output logic falling_edge
);

  localparam int unsigned      CNT_W   = filter_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any cycle where sync agrees with the output restarts the count, so only an
  // unbroken run of FILTER_CYCLES differing samples moves the output.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync != out_q) begin
      if (cnt_q == CNT_MAX) begin
        out_d  = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      out_q  <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_out     = out_q;
  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;

endmodule

// File: rtl/filtered_synchronizer.sv
// Multi-channel level synchronizer: a plain flop chain per channel followed by a
// glitch filter that only passes levels held for FILTER_CYCLES consecutive cycles.
module filtered_synchronizer
  import filtered_synchronizer_pkg::*;
#(
  parameter int unsigned       WIDTH         = 1,
  parameter int unsigned       STAGES        = 2,
  parameter int unsigned       FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rising_edge,
  output logic [WIDTH-1:0] falling_edge
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("filtered_synchronizer: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("filtered_synchronizer: STAGES=%0d outside %0d..%0d", STAGES, MIN_STAGES, MAX_STAGES);
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > MAX_FILTER_CYCLES) begin : g_bad_filter
    $error("filtered_synchronizer: FILTER_CYCLES=%0d outside 1..%0d", FILTER_CYCLES, MAX_FILTER_CYCLES);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    // Bare flop chain: nothing may sit between stages or metastability settling time is lost.
    logic [STAGES-1:0] sync_q, sync_d;

    assign sync_d = {sync_q[STAGES-2:0], data_in[i]};

    always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_q <= {STAGES{RESET_VALUE[i]}};
      else       sync_q <= sync_d;
    end

    glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_filter (
      .clock        (clock),
      .reset        (reset),
      .sync         (sync_q[STAGES-1]),
      .data_out     (data_out[i]),
      .rising_edge  (rising_edge[i]),
      .falling_edge (falling_edge[i])
    );
  end

endmodule
